// File: rtl/boot_loader_pkg.sv
// Shared constants, state encoding and a byte-lane helper for the boot loader.
package utils;

    localparam logic [7:0] BOOT_HELLO = 8'h99;
    localparam logic [7:0] BOOT_DONE  = 8'haa;

    typedef enum logic [2:0] {
        S_HELLO,
        S_HELLO_WAIT,
        S_LEN,
        S_PROG,
        S_FLUSH,
        S_DONE,
        S_DONE_WAIT,
        S_RUN
    } state_t;

    // Replace byte lane 'lane' of a little-endian word with 'b'.
    function automatic logic [31:0] set_lane(input logic [31:0] w, input logic [1:0] lane,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        r[8*lane +: 8] = b;
        return r;
    endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Bundle of UART, instruction-memory, core and status signals around the boot loader.
//
// Handshakes: rdata_ready is a one-cycle valid strobe with no back-pressure (the byte is
// taken or dropped in that cycle; ferr qualifies it). tx_start is a one-cycle request
// that may only be raised while tx_busy is low; tx_busy then rises and falls back when
// the byte has left. imem_we is a one-cycle write strobe, always accepted by the memory.
interface boot_loader_if #(
    parameter int IMEM_ADDR_W = 15
);
    import utils::*;

    logic [7:0]             sdata;
    logic                   tx_start;
    logic                   tx_busy;
    logic [7:0]             rdata;
    logic                   rdata_ready;
    logic                   ferr;
    logic                   imem_we;
    logic [IMEM_ADDR_W-1:0] imem_addr;
    logic [31:0]            imem_wdata;
    logic [7:0]             core_sdata;
    logic                   core_tx_start;
    logic                   core_tx_busy;
    logic [7:0]             core_rdata;
    logic                   core_rx_valid;
    logic                   boot_done;
    logic                   boot_err;
    state_t                 dbg_state;

    modport master (
        output sdata, tx_start, imem_we, imem_addr, imem_wdata,
        output core_tx_busy, core_rdata, core_rx_valid, boot_done, boot_err, dbg_state,
        input  tx_busy, rdata, rdata_ready, ferr, core_sdata, core_tx_start
    );

    modport slave (
        input  sdata, tx_start, imem_we, imem_addr, imem_wdata,
        input  core_tx_busy, core_rdata, core_rx_valid, boot_done, boot_err, dbg_state,
        output tx_busy, rdata, rdata_ready, ferr, core_sdata, core_tx_start
    );

endinterface

// File: rtl/boot_loader.sv
// UART boot loader: greets the host, receives a length-prefixed image into
// instruction memory, acknowledges, then hands the UART over to the core.
module boot_loader
    import utils::*;
#(
    parameter int IMEM_ADDR_W = 15,
    parameter int IMEM_WORDS  = 2 ** IMEM_ADDR_W
) (
    input  logic          clk,
    input  logic          rstn,
    boot_loader_if.master bus
);

    localparam logic [31:0] WORDS_L = 32'(IMEM_WORDS);
    localparam logic [IMEM_ADDR_W-1:0] ADDR_ONE = {{(IMEM_ADDR_W-1){1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic [7:0]             sdata_q, sdata_d;
    logic                   tx_start_q, tx_start_d;
    logic                   imem_we_q, imem_we_d;
    logic [IMEM_ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]            imem_wdata_q, imem_wdata_d;
    logic                   boot_done_q, boot_done_d;
    logic                   boot_err_q, boot_err_d;
    logic                   busy_seen_q, busy_seen_d;
    logic [31:0]            len_q, len_d;
    logic [31:0]            cnt_q, cnt_d;
    logic [31:0]            wbuf_q, wbuf_d;

    logic                   rx_ok;
    logic                   rx_bad;
    logic                   run;
    logic [1:0]             lane;
    logic [31:0]            cnt_inc;
    logic [31:0]            widx;
    logic [31:0]            len_new;

    assign rx_ok   = bus.rdata_ready & ~bus.ferr;
    assign rx_bad  = bus.rdata_ready & bus.ferr;
    assign run     = (state_q == S_RUN);
    assign lane    = cnt_q[1:0];
    assign cnt_inc = cnt_q + 32'd1;
    // Index of the word the current byte belongs to; kept 32 bits wide so an
    // image larger than the memory is detected instead of wrapping.
    assign widx    = {2'b00, cnt_q[31:2]};
    assign len_new = set_lane(len_q, lane, bus.rdata);

    // Next-state and next-output computation for the boot sequence.
    always_comb begin
        state_d      = state_q;
        sdata_d      = sdata_q;
        tx_start_d   = 1'b0;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_we_q ? imem_addr_q + ADDR_ONE : imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        boot_done_d  = boot_done_q;
        boot_err_d   = boot_err_q;
        busy_seen_d  = busy_seen_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        wbuf_d       = wbuf_q;

        case (state_q)
            S_HELLO, S_DONE: begin
                if (!bus.tx_busy) begin
                    tx_start_d  = 1'b1;
                    sdata_d     = (state_q == S_HELLO) ? BOOT_HELLO : BOOT_DONE;
                    busy_seen_d = 1'b0;
                    state_d     = (state_q == S_HELLO) ? S_HELLO_WAIT : S_DONE_WAIT;
                end
            end
            S_HELLO_WAIT, S_DONE_WAIT: begin
                // Wait for the byte to actually start and then finish.
                if (bus.tx_busy) begin
                    busy_seen_d = 1'b1;
                end else if (busy_seen_q) begin
                    busy_seen_d = 1'b0;
                    cnt_d       = 32'd0;
                    if (state_q == S_HELLO_WAIT) begin
                        state_d = S_LEN;
                    end else begin
                        state_d     = S_RUN;
                        boot_done_d = 1'b1;
                    end
                end
            end
            S_LEN: begin
                if (rx_bad) begin
                    boot_err_d = 1'b1;
                end else if (rx_ok) begin
                    len_d = len_new;
                    if (lane == 2'd3) begin
                        cnt_d       = 32'd0;
                        wbuf_d      = 32'd0;
                        imem_addr_d = '0;
                        state_d     = (len_new == 32'd0) ? S_DONE : S_PROG;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            S_PROG: begin
                if (rx_bad) begin
                    boot_err_d = 1'b1;
                end else if (rx_ok) begin
                    cnt_d  = cnt_inc;
                    wbuf_d = set_lane(wbuf_q, lane, bus.rdata);
                    if (lane == 2'd3) begin
                        wbuf_d = 32'd0;
                        if (widx < WORDS_L) begin
                            imem_we_d    = 1'b1;
                            imem_addr_d  = widx[IMEM_ADDR_W-1:0];
                            imem_wdata_d = set_lane(wbuf_q, 2'd3, bus.rdata);
                        end else begin
                            boot_err_d = 1'b1;
                        end
                    end
                    if (cnt_inc == len_q) begin
                        state_d = (lane == 2'd3) ? S_DONE : S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                // Unfilled upper lanes of wbuf are still zero from the last clear.
                if (widx < WORDS_L) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = widx[IMEM_ADDR_W-1:0];
                    imem_wdata_d = wbuf_q;
                end else begin
                    boot_err_d = 1'b1;
                end
                state_d = S_DONE;
            end
            default: begin
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= S_HELLO;
            sdata_q      <= 8'd0;
            tx_start_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= 32'd0;
            boot_done_q  <= 1'b0;
            boot_err_q   <= 1'b0;
            busy_seen_q  <= 1'b0;
            len_q        <= 32'd0;
            cnt_q        <= 32'd0;
            wbuf_q       <= 32'd0;
        end else begin
            state_q      <= state_d;
            sdata_q      <= sdata_d;
            tx_start_q   <= tx_start_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            boot_done_q  <= boot_done_d;
            boot_err_q   <= boot_err_d;
            busy_seen_q  <= busy_seen_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            wbuf_q       <= wbuf_d;
        end
    end

    // Once running, the UART is passed straight through to the core.
    assign bus.sdata         = run ? bus.core_sdata : sdata_q;
    assign bus.tx_start      = run ? bus.core_tx_start : tx_start_q;
    assign bus.core_tx_busy  = run ? bus.tx_busy : 1'b1;
    assign bus.core_rdata    = bus.rdata;
    assign bus.core_rx_valid = run & rx_ok;
    assign bus.imem_we       = imem_we_q;
    assign bus.imem_addr     = imem_addr_q;
    assign bus.imem_wdata    = imem_wdata_q;
    assign bus.boot_done     = boot_done_q;
    assign bus.boot_err      = boot_err_q;
    assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: table of boot images plus hand sequences for
// mid-transfer reset and run-mode pass-through.
module tb_boot_loader;
    import utils::*;

    logic clk;
    logic rstn;

    boot_loader_if #(.IMEM_ADDR_W(15)) bus ();

    // Memory shrunk to two words so the overflow path is reachable.
    boot_loader #(.IMEM_ADDR_W(15), .IMEM_WORDS(2)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int viol   = 0;

    logic [7:0]  tx_q[$];
    logic [14:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          busy_cnt = 0;

    // ---------------- uart_tx and imem models (sampled on negedge) ----------------
    always @(negedge clk) begin
        if (!rstn) begin
            bus.tx_busy = 1'b0;
            busy_cnt    = 0;
        end else begin
            if (bus.tx_start) begin
                if (bus.tx_busy && bus.dbg_state != S_RUN) viol++;
                tx_q.push_back(bus.sdata);
                bus.tx_busy = 1'b1;
                busy_cnt    = 6;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) bus.tx_busy = 1'b0;
            end
            if (bus.imem_we) begin
                wr_addr_q.push_back(bus.imem_addr);
                wr_data_q.push_back(bus.imem_wdata);
            end
        end
    end

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_state(input state_t target, input int budget, input string name);
        int n = 0;
        while (bus.dbg_state != target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(bus.dbg_state), 32'(target));
    endtask

    // ---------------- drivers ----------------
    task automatic send_rx(input logic [7:0] b, input logic f);
        @(posedge clk); #1;
        bus.rdata       = b;
        bus.ferr        = f;
        bus.rdata_ready = 1'b1;
        @(posedge clk); #1;
        bus.rdata_ready = 1'b0;
        bus.ferr        = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        chk("rst_state",      32'(bus.dbg_state), 32'(S_HELLO));
        chk("rst_sdata",      32'(bus.sdata), 32'h0);
        chk("rst_tx_start",   32'(bus.tx_start), 32'h0);
        chk("rst_imem_we",    32'(bus.imem_we), 32'h0);
        chk("rst_imem_addr",  32'(bus.imem_addr), 32'h0);
        chk("rst_imem_wdata", bus.imem_wdata, 32'h0);
        chk("rst_boot_done",  32'(bus.boot_done), 32'h0);
        chk("rst_boot_err",   32'(bus.boot_err), 32'h0);
        chk("rst_core_busy",  32'(bus.core_tx_busy), 32'h1);
        rstn = 1'b1;
        tx_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic send_len(input logic [31:0] len);
        for (int k = 0; k < 4; k++) send_rx(len[8*k +: 8], 1'b0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0]       len;
        int                n;
        logic [11:0][7:0]  data;
        int                ferr_idx;
        int                nwr;
        logic [2:0][31:0]  wd;
        logic [2:0][14:0]  wa;
        logic              err;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input int v);
        logic [31:0] l;
        int          budget;
        l      = vecs[v].len;
        budget = (l == 32'd0) ? 20 : 400;
        do_reset();
        wait_state(S_LEN, 100, "reach_len");
        send_len(l);
        for (int i = 0; i < vecs[v].n; i++) send_rx(vecs[v].data[i], i == vecs[v].ferr_idx);
        wait_state(S_RUN, budget, "reach_run");
        chk("boot_done", 32'(bus.boot_done), 32'h1);
        chk("boot_err",  32'(bus.boot_err), 32'(vecs[v].err));
        chk("tx_count",  32'(tx_q.size()), 32'd2);
        if (tx_q.size() >= 2) begin
            chk("tx_hello", 32'(tx_q[0]), 32'h99);
            chk("tx_done",  32'(tx_q[1]), 32'haa);
        end
        chk("wr_count", 32'(wr_data_q.size()), 32'(vecs[v].nwr));
        for (int i = 0; i < vecs[v].nwr && i < wr_data_q.size(); i++) begin
            chk("wr_addr", 32'(wr_addr_q[i]), 32'(vecs[v].wa[i]));
            chk("wr_data", wr_data_q[i], vecs[v].wd[i]);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main test ----------------
    initial begin
        rstn              = 1'b0;
        bus.rdata         = 8'h00;
        bus.rdata_ready   = 1'b0;
        bus.ferr          = 1'b0;
        bus.core_sdata    = 8'h00;
        bus.core_tx_start = 1'b0;
        bus.tx_busy       = 1'b0;

        // length 8, bytes 01..08
        vecs[0].len = 32'd8; vecs[0].n = 8; vecs[0].ferr_idx = -1;
        for (int i = 0; i < 8; i++) vecs[0].data[i] = 8'(i + 1);
        vecs[0].nwr = 2; vecs[0].err = 1'b0;
        vecs[0].wa[0] = 15'd0; vecs[0].wd[0] = 32'h04030201;
        vecs[0].wa[1] = 15'd1; vecs[0].wd[1] = 32'h08070605;
        // length 0
        vecs[1].len = 32'd0; vecs[1].n = 0; vecs[1].ferr_idx = -1;
        vecs[1].nwr = 0; vecs[1].err = 1'b0;
        // length 5, bytes 11..15, partial last word
        vecs[2].len = 32'd5; vecs[2].n = 5; vecs[2].ferr_idx = -1;
        for (int i = 0; i < 5; i++) vecs[2].data[i] = 8'(8'h11 + i);
        vecs[2].nwr = 2; vecs[2].err = 1'b0;
        vecs[2].wa[0] = 15'd0; vecs[2].wd[0] = 32'h14131211;
        vecs[2].wa[1] = 15'd1; vecs[2].wd[1] = 32'h00000015;
        // length 8, framing error on 3rd program byte, 9 bytes sent
        vecs[3].len = 32'd8; vecs[3].n = 9; vecs[3].ferr_idx = 2;
        vecs[3].data[0] = 8'h01; vecs[3].data[1] = 8'h02; vecs[3].data[2] = 8'hee;
        for (int i = 3; i < 9; i++) vecs[3].data[i] = 8'(i);
        vecs[3].nwr = 2; vecs[3].err = 1'b1;
        vecs[3].wa[0] = 15'd0; vecs[3].wd[0] = 32'h04030201;
        vecs[3].wa[1] = 15'd1; vecs[3].wd[1] = 32'h08070605;
        // length 12 into a two-word memory: third word suppressed
        vecs[4].len = 32'd12; vecs[4].n = 12; vecs[4].ferr_idx = -1;
        for (int i = 0; i < 12; i++) vecs[4].data[i] = 8'(8'h21 + i);
        vecs[4].nwr = 2; vecs[4].err = 1'b1;
        vecs[4].wa[0] = 15'd0; vecs[4].wd[0] = 32'h24232221;
        vecs[4].wa[1] = 15'd1; vecs[4].wd[1] = 32'h28272625;
        // length 6, bytes a0..a5
        vecs[5].len = 32'd6; vecs[5].n = 6; vecs[5].ferr_idx = -1;
        for (int i = 0; i < 6; i++) vecs[5].data[i] = 8'(8'ha0 + i);
        vecs[5].nwr = 2; vecs[5].err = 1'b0;
        vecs[5].wa[0] = 15'd0; vecs[5].wd[0] = 32'ha3a2a1a0;
        vecs[5].wa[1] = 15'd1; vecs[5].wd[1] = 32'h0000a5a4;

        repeat (2) @(posedge clk);

        for (int v = 0; v < 6; v++) run_vec(v);

        // ---- reset in the middle of programming ----
        do_reset();
        wait_state(S_LEN, 100, "mid_reach_len");
        send_len(32'd8);
        for (int i = 0; i < 5; i++) send_rx(8'(i + 1), 1'b0);
        chk("mid_state_prog", 32'(bus.dbg_state), 32'(S_PROG));
        chk("mid_wr_count", 32'(wr_data_q.size()), 32'd1);
        do_reset();

        // ---- outside run: core requests and rx bytes are ignored ----
        bus.rdata         = 8'h5a;
        bus.rdata_ready   = 1'b1;
        bus.core_sdata    = 8'h41;
        bus.core_tx_start = 1'b1;
        #1;
        chk("pre_run_rx_valid", 32'(bus.core_rx_valid), 32'h0);
        chk("pre_run_core_busy", 32'(bus.core_tx_busy), 32'h1);
        @(posedge clk); #1;
        bus.rdata_ready   = 1'b0;
        bus.core_tx_start = 1'b0;
        wait_state(S_LEN, 100, "fresh_reach_len");
        chk("fresh_tx_count", 32'(tx_q.size()), 32'd1);
        if (tx_q.size() >= 1) chk("fresh_hello", 32'(tx_q[0]), 32'h99);

        // ---- run mode pass-through ----
        send_len(32'd0);
        wait_state(S_RUN, 20, "run_reach");
        @(posedge clk); #1;
        bus.core_sdata    = 8'h41;
        bus.core_tx_start = 1'b1;
        #1;
        chk("run_tx_start", 32'(bus.tx_start), 32'h1);
        chk("run_sdata", 32'(bus.sdata), 32'h41);
        chk("run_core_busy_idle", 32'(bus.core_tx_busy), 32'h0);
        @(posedge clk); #1;
        bus.core_tx_start = 1'b0;
        @(negedge clk);
        chk("run_core_busy_follow", 32'(bus.core_tx_busy), 32'h1);
        chk("run_tx_count", 32'(tx_q.size()), 32'd3);
        if (tx_q.size() >= 3) chk("run_tx_byte", 32'(tx_q[2]), 32'h41);
        @(posedge clk); #1;
        bus.rdata       = 8'h5a;
        bus.rdata_ready = 1'b1;
        #1;
        chk("run_rx_valid", 32'(bus.core_rx_valid), 32'h1);
        chk("run_rx_data", 32'(bus.core_rdata), 32'h5a);
        bus.ferr = 1'b1;
        #1;
        chk("run_rx_ferr", 32'(bus.core_rx_valid), 32'h0);
        @(posedge clk); #1;
        bus.rdata_ready = 1'b0;
        bus.ferr        = 1'b0;
        #1;
        chk("run_rx_idle", 32'(bus.core_rx_valid), 32'h0);
        chk("run_boot_done", 32'(bus.boot_done), 32'h1);

        chk("tx_start_while_busy", 32'(viol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 Parameter IMEM_ADDR_W, default 15, word-address width of instruction memory.
REQ-002 Parameter IMEM_WORDS, default 2**IMEM_ADDR_W, capacity in 32-bit words.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 rstn  in  1  synchronous, active-low reset.
REQ-005 sdata  out  8  byte to uart_tx.
REQ-006 tx_start  out  1  one-cycle start strobe to uart_tx.
REQ-007 tx_busy  in  1  uart_tx busy.
REQ-008 rdata  in  8  byte from uart_rx.
REQ-009 rdata_ready  in  1  one-cycle byte-valid strobe from uart_rx.
REQ-010 ferr  in  1  framing error, qualified by rdata_ready.
REQ-011 imem_we / imem_addr / imem_wdata  out  1 / IMEM_ADDR_W / 32  instruction-memory write port.
REQ-012 core_sdata, core_tx_start  in  8, 1  core transmit request; core_tx_busy  out  1.
REQ-013 core_rdata, core_rx_valid  out  8, 1  received byte to core.
REQ-014 boot_done  out  1  high in RUN; core held while low.
REQ-015 boot_err  out  1  sticky error flag.

Function
REQ-016 States: S_HELLO, S_HELLO_WAIT, S_LEN, S_PROG, S_FLUSH, S_DONE, S_DONE_WAIT, S_RUN; reset state S_HELLO.
REQ-017 S_HELLO: when tx_busy=0, tx_start=1 for one cycle with sdata=8'h99 -> S_HELLO_WAIT.
REQ-018 S_HELLO_WAIT: after tx_busy has risen and then fallen -> S_LEN.
REQ-019 S_LEN: four valid bytes form 32-bit byte length, little-endian (first byte = bits 7:0).
REQ-020 After the 4th length byte: length 0 -> S_DONE; else -> S_PROG with word address 0 and byte count 0.
REQ-021 S_PROG: bytes packed little-endian into a 32-bit word; on the 4th byte of a word, imem_we=1 for exactly the next cycle with imem_addr=current word index, then index+1.
REQ-022 When the received byte count equals length: a complete word -> S_DONE after its write; a partial word -> S_FLUSH, which writes it zero-padded in the upper bytes, one cycle, then -> S_DONE.
REQ-023 Word index >= IMEM_WORDS: write suppressed, boot_err set, bytes still counted to length.
REQ-024 rdata_ready with ferr=1: byte discarded (not counted), boot_err set.
REQ-025 S_DONE: when tx_busy=0, send 8'haa as in REQ-017 -> S_DONE_WAIT; when tx_busy falls -> S_RUN.
REQ-026 S_RUN: boot_done=1; sdata/tx_start driven from core_sdata/core_tx_start; core_tx_busy=tx_busy; core_rdata=rdata; core_rx_valid=rdata_ready & ~ferr.
REQ-027 Outside S_RUN: core_tx_start ignored, core_tx_busy=1, core_rx_valid=0.
REQ-028 rdata_ready outside S_LEN/S_PROG/S_RUN: ignored, no error.
REQ-029 tx_start never asserted while tx_busy=1 (outside S_RUN, where the core owns this rule).
REQ-030 Byte counter 32 bits, no wrap; imem_addr increments only on an accepted write.

Reset
REQ-031 rstn=0 at any clock edge, including mid-transfer: state -> S_HELLO; sdata=0, tx_start=0, imem_we=0, imem_addr=0, imem_wdata=0, boot_done=0, boot_err=0, core_rx_valid=0; counters and word buffer cleared.
REQ-032 First 8'h99 is issued no earlier than the first cycle after rstn=1.

Structure
REQ-033 Constants BOOT_HELLO=8'h99 and BOOT_DONE=8'haa and the state enum typedef reside in package utils.
REQ-034 Single flat module, no sub-modules; uart_tx/uart_rx are instantiated by the parent.

Verification
REQ-035 Length 8, bytes 01..08 -> writes addr0=32'h04030201, addr1=32'h08070605, then 8'haa, boot_done=1.
REQ-036 Length 0 -> no imem_we, 8'haa sent immediately after length, boot_done=1.
REQ-037 Length 5, bytes 11..15 -> addr0=32'h14131211, addr1=32'h00000015 via S_FLUSH.
REQ-038 Length 8 with ferr on 3rd program byte, 9 bytes sent -> boot_err=1, same two words as REQ-035 (bad byte excluded).
REQ-039 rstn pulsed low mid-S_PROG -> all outputs at reset values next cycle, fresh 8'h99 sent.
REQ-040 In S_RUN: core sends 8'h41 -> uart_tx sees 8'h41; received 8'h5a -> core_rx_valid pulse with core_rdata=8'h5a.
